alu_csr_bank: RTL and testbench

ALU_CSR_BANK -- requirements
Module: alu_csr_bank

---
 rtl/alu_csr_pkg.sv | 51 +++++
 rtl/d_ff_async_en.sv | 21 ++
 rtl/alu_csr_bank.sv | 227 ++++++++++++++++++++++
 tb/tb_alu_csr_bank.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_csr_pkg.sv
// Shared definitions for the ALU CSR bank: register map, STATUS bit
// positions, default CTRL field positions and the address decoder.
package alu_csr_pkg;

  // Word offsets of the registers; DATA_k lives at REG_DATA0 + k
  localparam int REG_CTRL   = 0;
  localparam int REG_STATUS = 1;
  localparam int REG_RESULT = 2;
  localparam int REG_IRQ_EN = 3;
  localparam int REG_DATA0  = 4;

  // STATUS register bit positions
  localparam int STAT_OUT_EMPTY = 0;
  localparam int STAT_IN_FULL   = 1;
  localparam int STAT_PENDING   = 2;
  localparam int STAT_RES_VALID = 3;
  localparam int STAT_ERR_BUSY  = 4;
  localparam int STAT_ERR_EMPTY = 5;

  // CTRL field positions (ID and opcode positions are parameter defaults)
  localparam int CTRL_START_BIT    = 0;
  localparam int DEF_OPERATION_BIT = 1;
  localparam int DEF_ID_BIT        = 8;

  // IRQ_EN bit positions
  localparam int IRQ_EN_RES = 0;
  localparam int IRQ_EN_ERR = 1;

  // Which register an address selects
  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CTRL,
    SEL_STATUS,
    SEL_RESULT,
    SEL_IRQ_EN,
    SEL_DATA
  } reg_sel_e;

  // Map a word address onto a register class; unmapped addresses give SEL_NONE
  function automatic reg_sel_e decode_addr(input int a, input int n_ops);
    reg_sel_e sel;
    sel = SEL_NONE;
    if (a == REG_CTRL)        sel = SEL_CTRL;
    else if (a == REG_STATUS) sel = SEL_STATUS;
    else if (a == REG_RESULT) sel = SEL_RESULT;
    else if (a == REG_IRQ_EN) sel = SEL_IRQ_EN;
    else if ((a >= REG_DATA0) && (a < REG_DATA0 + n_ops)) sel = SEL_DATA;
    return sel;
  endfunction

endpackage

// File: rtl/d_ff_async_en.sv
// Storage flop with load enable and asynchronous active-low clear.
module d_ff_async_en #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  // Load i_d when enabled; clear immediately on reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= '0;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/alu_csr_bank.sv
// APB-style CSR bank in front of an ALU: collects operands and a command,
// pushes them as one word into FIFO_IN, and pulls results from FIFO_OUT
// into a single-entry RESULT register with status, sticky errors and irq.
module alu_csr_bank
  import alu_csr_pkg::*;
#(
  parameter int APB_BUS_SIZE   = 32,
  parameter int ADDR_W         = 4,
  parameter int DATA_SIZE      = 16,
  parameter int NUM_OPERANDS   = 2,
  parameter int ID_SIZE        = 8,
  parameter int ID_BIT         = DEF_ID_BIT,
  parameter int OPERATION_SIZE = 2,
  parameter int OPERATION_BIT  = DEF_OPERATION_BIT,
  parameter int FIFO_OUT_WIDTH = 25,
  parameter int FIFO_IN_WIDTH  = NUM_OPERANDS*DATA_SIZE+ID_SIZE+OPERATION_SIZE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic                      rd_en,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [APB_BUS_SIZE-1:0]   wdata,
  output logic [APB_BUS_SIZE-1:0]   rdata,
  output logic                      fifo_in_push,
  output logic [FIFO_IN_WIDTH-1:0]  fifo_in_data,
  input  logic                      fifo_in_full,
  output logic                      fifo_out_pop,
  input  logic [FIFO_OUT_WIDTH-1:0] fifo_out_data,
  input  logic                      fifo_out_empty,
  output logic                      irq
);

  // Register state
  logic [OPERATION_SIZE-1:0] r_op;
  logic [ID_SIZE-1:0]        r_id;
  logic [DATA_SIZE-1:0]      r_data [NUM_OPERANDS];
  logic [FIFO_OUT_WIDTH-1:0] r_res;
  logic [1:0]                r_irq_en;
  logic                      r_pending;
  logic                      r_res_valid;
  logic                      r_err_busy;
  logic                      r_err_empty;
  logic                      r_irq;

  // Decode and control
  reg_sel_e                  w_sel;
  logic [NUM_OPERANDS-1:0]   w_data_hit;
  logic                      w_wr_ctrl;
  logic                      w_wr_status;
  logic                      w_wr_irq_en;
  logic                      w_wr_data_any;
  logic                      w_ctrl_accept;
  logic                      w_start;
  logic                      w_set_busy;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_rd_result;

  // Next-state values
  logic                      w_pending_d;
  logic                      w_res_valid_d;
  logic                      w_err_busy_d;
  logic                      w_err_empty_d;
  logic                      w_irq_d;

  // Datapath views
  logic [APB_BUS_SIZE-1:0]   w_status;
  logic [APB_BUS_SIZE-1:0]   w_rdata;
  logic [FIFO_IN_WIDTH-1:0]  w_fifo_in_data;
  logic                      w_unused_wdata;

  assign w_sel = decode_addr(int'(addr), NUM_OPERANDS);

  for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_data_hit
    assign w_data_hit[k] = (w_sel == SEL_DATA) && (int'(addr) == REG_DATA0 + k);
  end

  assign w_wr_ctrl     = wr_en & (w_sel == SEL_CTRL);
  assign w_wr_status   = wr_en & (w_sel == SEL_STATUS);
  assign w_wr_irq_en   = wr_en & (w_sel == SEL_IRQ_EN);
  assign w_wr_data_any = wr_en & (|w_data_hit);
  assign w_rd_result   = rd_en & (w_sel == SEL_RESULT);

  // Command registers are frozen while a command waits, so the FIFO_IN word
  // cannot change between acceptance and the push.
  assign w_ctrl_accept = w_wr_ctrl & ~r_pending;
  assign w_start       = w_ctrl_accept & wdata[CTRL_START_BIT];
  assign w_set_busy    = r_pending & (w_wr_ctrl | w_wr_data_any);

  assign w_push = r_pending & ~fifo_in_full;
  // Gated by rst_n so a non-empty FIFO_OUT cannot pop during reset
  assign w_pop  = rst_n & ~r_res_valid & ~fifo_out_empty;

  // Next-state for the handshake flags, sticky errors and interrupt
  always_comb begin
    w_pending_d   = r_pending;
    w_res_valid_d = r_res_valid;
    if (r_pending) begin
      w_pending_d = fifo_in_full;
    end else if (w_start) begin
      w_pending_d = 1'b1;
    end
    if (w_pop) begin
      w_res_valid_d = 1'b1;
    end else if (w_rd_result) begin
      w_res_valid_d = 1'b0;
    end
    w_err_busy_d  = (r_err_busy & ~(w_wr_status & wdata[STAT_ERR_BUSY])) | w_set_busy;
    w_err_empty_d = (r_err_empty & ~(w_wr_status & wdata[STAT_ERR_EMPTY]))
                    | (w_rd_result & ~r_res_valid);
    w_irq_d = (r_irq_en[IRQ_EN_RES] & r_res_valid)
              | (r_irq_en[IRQ_EN_ERR] & (r_err_busy | r_err_empty));
  end

  d_ff_async_en #(.WIDTH(OPERATION_SIZE)) u_op (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(w_ctrl_accept),
    .i_d(wdata[OPERATION_BIT +: OPERATION_SIZE]), .o_q(r_op)
  );

  d_ff_async_en #(.WIDTH(ID_SIZE)) u_id (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(w_ctrl_accept),
    .i_d(wdata[ID_BIT +: ID_SIZE]), .o_q(r_id)
  );

  for (genvar k = 0; k < NUM_OPERANDS; k++) begin : g_data_reg
    d_ff_async_en #(.WIDTH(DATA_SIZE)) u_data (
      .i_clk(clk), .i_rst_n(rst_n), .i_en(wr_en & w_data_hit[k] & ~r_pending),
      .i_d(wdata[DATA_SIZE-1:0]), .o_q(r_data[k])
    );
  end

  d_ff_async_en #(.WIDTH(FIFO_OUT_WIDTH)) u_res (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(w_pop),
    .i_d(fifo_out_data), .o_q(r_res)
  );

  d_ff_async_en #(.WIDTH(2)) u_irq_en (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(w_wr_irq_en),
    .i_d(wdata[1:0]), .o_q(r_irq_en)
  );

  d_ff_async_en #(.WIDTH(1)) u_pending (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(1'b1),
    .i_d(w_pending_d), .o_q(r_pending)
  );

  d_ff_async_en #(.WIDTH(1)) u_res_valid (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(1'b1),
    .i_d(w_res_valid_d), .o_q(r_res_valid)
  );

  d_ff_async_en #(.WIDTH(1)) u_err_busy (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(1'b1),
    .i_d(w_err_busy_d), .o_q(r_err_busy)
  );

  d_ff_async_en #(.WIDTH(1)) u_err_empty (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(1'b1),
    .i_d(w_err_empty_d), .o_q(r_err_empty)
  );

  d_ff_async_en #(.WIDTH(1)) u_irq (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(1'b1),
    .i_d(w_irq_d), .o_q(r_irq)
  );

  // Assemble the live STATUS word
  always_comb begin
    w_status                 = '0;
    w_status[STAT_OUT_EMPTY] = fifo_out_empty;
    w_status[STAT_IN_FULL]   = fifo_in_full;
    w_status[STAT_PENDING]   = r_pending;
    w_status[STAT_RES_VALID] = r_res_valid;
    w_status[STAT_ERR_BUSY]  = r_err_busy;
    w_status[STAT_ERR_EMPTY] = r_err_empty;
  end

  // Combinational read mux, zero when no read is strobed
  always_comb begin
    w_rdata = '0;
    if (rd_en) begin
      case (w_sel)
        SEL_CTRL: begin
          w_rdata[ID_BIT +: ID_SIZE]               = r_id;
          w_rdata[OPERATION_BIT +: OPERATION_SIZE] = r_op;
          w_rdata[CTRL_START_BIT]                  = r_pending;
        end
        SEL_STATUS: w_rdata = w_status;
        SEL_RESULT: begin
          if (r_res_valid) begin
            w_rdata[FIFO_OUT_WIDTH-1:0] = r_res;
          end
        end
        SEL_IRQ_EN: w_rdata[1:0] = r_irq_en;
        SEL_DATA: begin
          for (int k = 0; k < NUM_OPERANDS; k++) begin
            if (w_data_hit[k]) begin
              w_rdata[DATA_SIZE-1:0] = r_data[k];
            end
          end
        end
        default: w_rdata = '0;
      endcase
    end
  end

  // Pack {DATA_n-1..DATA_0, ID, OP} for FIFO_IN
  always_comb begin
    w_fifo_in_data = '0;
    w_fifo_in_data[OPERATION_SIZE-1:0]        = r_op;
    w_fifo_in_data[OPERATION_SIZE +: ID_SIZE] = r_id;
    for (int k = 0; k < NUM_OPERANDS; k++) begin
      w_fifo_in_data[OPERATION_SIZE + ID_SIZE + k*DATA_SIZE +: DATA_SIZE] = r_data[k];
    end
  end

  // Not every write-data bit maps onto a register field
  assign w_unused_wdata = ^wdata;

  assign rdata        = w_rdata;
  assign fifo_in_data = w_fifo_in_data;
  assign fifo_in_push = w_push;
  assign fifo_out_pop = w_pop;
  assign irq          = r_irq;

endmodule

// File: tb/tb_alu_csr_bank.sv
// Self-checking bench for alu_csr_bank: directed scenarios plus a randomized
// run compared against a transaction-level model of the register bank.
module tb_alu_csr_bank;

  localparam int AW   = 4;
  localparam int BW   = 32;
  localparam int DW   = 16;
  localparam int NOPS = 2;
  localparam int IDW  = 8;
  localparam int OPW  = 2;
  localparam int OUTW = 25;
  localparam int INW  = NOPS*DW + IDW + OPW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_en;
  logic            rd_en;
  logic [AW-1:0]   addr;
  logic [BW-1:0]   wdata;
  logic [BW-1:0]   rdata;
  logic            fifo_in_push;
  logic [INW-1:0]  fifo_in_data;
  logic            fifo_in_full;
  logic            fifo_out_pop;
  logic [OUTW-1:0] fifo_out_data;
  logic            fifo_out_empty;
  logic            irq;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_csr_bank #(
    .APB_BUS_SIZE(BW), .ADDR_W(AW), .DATA_SIZE(DW), .NUM_OPERANDS(NOPS),
    .ID_SIZE(IDW), .ID_BIT(8), .OPERATION_SIZE(OPW), .OPERATION_BIT(1),
    .FIFO_OUT_WIDTH(OUTW), .FIFO_IN_WIDTH(INW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wdata(wdata), .rdata(rdata), .fifo_in_push(fifo_in_push),
    .fifo_in_data(fifo_in_data), .fifo_in_full(fifo_in_full),
    .fifo_out_pop(fifo_out_pop), .fifo_out_data(fifo_out_data),
    .fifo_out_empty(fifo_out_empty), .irq(irq)
  );

  // Bench-side FIFO_OUT contents (head is fq[0])
  logic [OUTW-1:0] fq[$];

  // Architectural model state
  logic [OPW-1:0]  m_op;
  logic [IDW-1:0]  m_id;
  logic [DW-1:0]   m_data [NOPS];
  logic [OUTW-1:0] m_res;
  logic [1:0]      m_irq_en;
  bit              m_pending, m_res_valid, m_err_busy, m_err_empty, m_irq;

  // Model predictions and DUT samples for the current cycle
  bit              e_push, e_pop, e_irq;
  logic [BW-1:0]   e_rdata;
  logic [INW-1:0]  e_fid;
  logic            s_push, s_pop, s_irq;
  logic [BW-1:0]   s_rdata;
  logic [INW-1:0]  s_fid;

  task automatic modelReset();
    m_op = '0; m_id = '0; m_res = '0; m_irq_en = '0;
    for (int k = 0; k < NOPS; k++) m_data[k] = '0;
    m_pending = 0; m_res_valid = 0; m_err_busy = 0; m_err_empty = 0; m_irq = 0;
  endtask

  task automatic driveFifoOut();
    fifo_out_empty = (fq.size() == 0);
    fifo_out_data  = (fq.size() == 0) ? '0 : fq[0];
  endtask

  // What the bank should show this cycle, from the model and current inputs
  task automatic modelEval();
    e_push = m_pending && !fifo_in_full;
    e_pop  = !m_res_valid && (fq.size() != 0);
    e_irq  = m_irq;
    e_fid  = {m_data[1], m_data[0], m_id, m_op};
    e_rdata = '0;
    if (rd_en) begin
      case (int'(addr))
        0: e_rdata = (32'(m_id) << 8) | (32'(m_op) << 1) | 32'(m_pending);
        1: e_rdata = 32'(fq.size() == 0) | (32'(fifo_in_full) << 1) | (32'(m_pending) << 2)
                     | (32'(m_res_valid) << 3) | (32'(m_err_busy) << 4) | (32'(m_err_empty) << 5);
        2: e_rdata = m_res_valid ? 32'(m_res) : 32'h0;
        3: e_rdata = 32'(m_irq_en);
        4: e_rdata = 32'(m_data[0]);
        5: e_rdata = 32'(m_data[1]);
        default: e_rdata = '0;
      endcase
    end
  endtask

  // Advance the model by one clock using this cycle's bus and FIFO inputs
  task automatic modelCommit();
    bit was_pending;
    bit irq_next;
    irq_next = (m_irq_en[0] && m_res_valid) || (m_irq_en[1] && (m_err_busy || m_err_empty));
    was_pending = m_pending;
    if (was_pending && !fifo_in_full) m_pending = 0;
    if (wr_en) begin
      case (int'(addr))
        0: begin
          if (was_pending) m_err_busy = 1;
          else begin
            m_op = wdata[2:1];
            m_id = wdata[15:8];
            if (wdata[0]) m_pending = 1;
          end
        end
        1: begin
          if (wdata[4]) m_err_busy = 0;
          if (wdata[5]) m_err_empty = 0;
        end
        3: m_irq_en = wdata[1:0];
        4, 5: begin
          if (was_pending) m_err_busy = 1;
          else m_data[int'(addr) - 4] = wdata[15:0];
        end
        default: ;
      endcase
    end
    if (rd_en && int'(addr) == 2) begin
      if (m_res_valid) m_res_valid = 0;
      else m_err_empty = 1;
    end
    if (e_pop) begin
      m_res = fq[0];
      m_res_valid = 1;
    end
    m_irq = irq_next;
  endtask

  // One clock: sample before the rising edge, update model after it,
  // let FIFO_OUT react on the falling edge
  task automatic tick();
    #1;
    modelEval();
    s_push  = fifo_in_push;
    s_pop   = fifo_out_pop;
    s_irq   = irq;
    s_rdata = rdata;
    s_fid   = fifo_in_data;
    @(posedge clk);
    #1;
    modelCommit();
    @(negedge clk);
    if (s_pop && fq.size() != 0) fq.delete(0);
    driveFifoOut();
  endtask

  task automatic busWrite(input int a, input logic [BW-1:0] d);
    addr = AW'(a); wdata = d; wr_en = 1'b1;
    tick();
    wr_en = 1'b0; wdata = '0;
  endtask

  task automatic busRead(input int a, output logic [BW-1:0] d);
    addr = AW'(a); rd_en = 1'b1;
    tick();
    d = s_rdata;
    rd_en = 1'b0;
  endtask

  localparam logic [INW-1:0] EXP_CMD = {16'h0005, 16'h0003, 8'h2A, 2'b01};

  task automatic test_reset();
    logic [BW-1:0] d;
    rst_n = 1'b0;
    fifo_out_empty = 1'b0;
    fifo_out_data = 25'h155;
    rd_en = 1'b1; addr = 4'd2;
    #3;
    n_checks++; if (fifo_out_pop !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pop: got %b want 0", fifo_out_pop); end
    n_checks++; if (fifo_in_push !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_push: got %b want 0", fifo_in_push); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq: got %b want 0", irq); end
    n_checks++; if (fifo_in_data !== '0) begin n_fail++; $display("[TB] FAIL reset_fifo_in_data: got %h want 0", fifo_in_data); end
    n_checks++; if (rdata !== '0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h want 0", rdata); end
    rd_en = 1'b0;
    driveFifoOut();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    busRead(1, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("[TB] FAIL reset_status: got %h want 1", d); end
    busRead(0, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_ctrl: got %h want 0", d); end
    busRead(3, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_irq_en: got %h want 0", d); end
    busWrite(9, 32'hFFFF_FFFF);
    busRead(9, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL unmapped_read: got %h want 0", d); end
  endtask

  task automatic test_push();
    logic [BW-1:0] d;
    busWrite(4, 32'h0003);
    busWrite(5, 32'h0005);
    busWrite(0, 32'h0000_2A03);
    n_checks++; if (s_push !== 1'b0) begin n_fail++; $display("[TB] FAIL push_early: got %b want 0", s_push); end
    tick();
    n_checks++; if (s_push !== 1'b1) begin n_fail++; $display("[TB] FAIL push_strobe: got %b want 1", s_push); end
    n_checks++; if (s_fid !== EXP_CMD) begin n_fail++; $display("[TB] FAIL push_data: got %h want %h", s_fid, EXP_CMD); end
    tick();
    n_checks++; if (s_push !== 1'b0) begin n_fail++; $display("[TB] FAIL push_single: got %b want 0", s_push); end
    busRead(0, d);
    n_checks++; if (d !== 32'h2A02) begin n_fail++; $display("[TB] FAIL ctrl_readback: got %h want 2a02", d); end
    busRead(5, d);
    n_checks++; if (d !== 32'h5) begin n_fail++; $display("[TB] FAIL data1_readback: got %h want 5", d); end
  endtask

  task automatic test_full_backpressure();
    logic [BW-1:0] d;
    int pushes;
    fifo_in_full = 1'b1;
    busWrite(0, 32'h0000_2A03);
    pushes = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (s_push === 1'b1) pushes++;
    end
    n_checks++; if (pushes != 0) begin n_fail++; $display("[TB] FAIL full_no_push: got %0d pushes want 0", pushes); end
    busRead(1, d);
    n_checks++; if (d !== 32'h7) begin n_fail++; $display("[TB] FAIL full_status: got %h want 7", d); end
    fifo_in_full = 1'b0;
    tick();
    n_checks++; if (s_push !== 1'b1) begin n_fail++; $display("[TB] FAIL full_release_push: got %b want 1", s_push); end
    tick();
    n_checks++; if (s_push !== 1'b0) begin n_fail++; $display("[TB] FAIL full_release_single: got %b want 0", s_push); end
    busRead(1, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("[TB] FAIL full_status_after: got %h want 1", d); end
  endtask

  task automatic test_busy_err();
    logic [BW-1:0] d;
    fifo_in_full = 1'b1;
    busWrite(0, 32'h0000_2A03);
    busWrite(4, 32'h1234);
    busRead(4, d);
    n_checks++; if (d !== 32'h3) begin n_fail++; $display("[TB] FAIL busy_data_kept: got %h want 3", d); end
    busRead(1, d);
    n_checks++; if (d !== 32'h17) begin n_fail++; $display("[TB] FAIL busy_status: got %h want 17", d); end
    busWrite(1, 32'h10);
    busRead(1, d);
    n_checks++; if (d !== 32'h07) begin n_fail++; $display("[TB] FAIL busy_w1c: got %h want 7", d); end
    fifo_in_full = 1'b0;
    tick();
    n_checks++; if (s_push !== 1'b1 || s_fid !== EXP_CMD) begin n_fail++; $display("[TB] FAIL busy_push: got push=%b data=%h want push=1 data=%h", s_push, s_fid, EXP_CMD); end
    tick();
  endtask

  task automatic test_result();
    logic [BW-1:0] d;
    fq.push_back(25'h1ABCDEF);
    fq.push_back(25'h0000001);
    driveFifoOut();
    tick();
    n_checks++; if (s_pop !== 1'b1) begin n_fail++; $display("[TB] FAIL first_pop: got %b want 1", s_pop); end
    tick();
    n_checks++; if (s_pop !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_pop: got %b want 0", s_pop); end
    busRead(2, d);
    n_checks++; if (d !== 32'h01AB_CDEF) begin n_fail++; $display("[TB] FAIL result_first: got %h want 01abcdef", d); end
    n_checks++; if (s_pop !== 1'b0) begin n_fail++; $display("[TB] FAIL read_cycle_pop: got %b want 0", s_pop); end
    tick();
    n_checks++; if (s_pop !== 1'b1) begin n_fail++; $display("[TB] FAIL second_pop: got %b want 1", s_pop); end
    busRead(2, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("[TB] FAIL result_second: got %h want 1", d); end
    tick();
    n_checks++; if (s_pop !== 1'b0) begin n_fail++; $display("[TB] FAIL empty_no_pop: got %b want 0", s_pop); end
    busRead(2, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("[TB] FAIL result_empty: got %h want 0", d); end
    busRead(1, d);
    n_checks++; if (d !== 32'h21) begin n_fail++; $display("[TB] FAIL err_empty_status: got %h want 21", d); end
    busWrite(1, 32'h20);
    busRead(1, d);
    n_checks++; if (d !== 32'h01) begin n_fail++; $display("[TB] FAIL err_empty_w1c: got %h want 1", d); end
  endtask

  task automatic test_irq();
    logic [BW-1:0] d;
    busWrite(3, 32'h1);
    busRead(3, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("[TB] FAIL irq_en_readback: got %h want 1", d); end
    fq.push_back(25'h00ABCDE);
    driveFifoOut();
    tick();
    n_checks++; if (s_pop !== 1'b1 || s_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_pop_cycle: got pop=%b irq=%b want pop=1 irq=0", s_pop, s_irq); end
    tick();
    n_checks++; if (s_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_latency: got %b want 0", s_irq); end
    tick();
    n_checks++; if (s_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_assert: got %b want 1", s_irq); end
    busRead(2, d);
    n_checks++; if (d !== 32'h000A_BCDE) begin n_fail++; $display("[TB] FAIL irq_result: got %h want 000abcde", d); end
    tick();
    n_checks++; if (s_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_hold: got %b want 1", s_irq); end
    tick();
    n_checks++; if (s_irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_deassert: got %b want 0", s_irq); end
    busWrite(3, 32'h0);
  endtask

  task automatic test_reset_mid_pending();
    logic [BW-1:0] d;
    int pushes;
    busWrite(3, 32'h2);
    fifo_in_full = 1'b1;
    busWrite(0, 32'h0000_0103);
    busWrite(4, 32'hBEEF);
    tick();
    tick();
    n_checks++; if (s_irq !== 1'b1) begin n_fail++; $display("[TB] FAIL err_irq: got %b want 1", s_irq); end
    #2;
    rst_n = 1'b0;
    fifo_in_full = 1'b0;
    #1;
    n_checks++; if (fifo_in_push !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_push: got %b want 0", fifo_in_push); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_irq: got %b want 0", irq); end
    n_checks++; if (fifo_in_data !== '0) begin n_fail++; $display("[TB] FAIL rst_fifo_in_data: got %h want 0", fifo_in_data); end
    n_checks++; if (fifo_out_pop !== 1'b0 || rdata !== '0) begin n_fail++; $display("[TB] FAIL rst_pop_rdata: got pop=%b rdata=%h want 0", fifo_out_pop, rdata); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    pushes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (s_push !== 1'b0) pushes++;
    end
    n_checks++; if (pushes != 0) begin n_fail++; $display("[TB] FAIL rst_lost_start: got %0d pushes want 0", pushes); end
    busRead(1, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("[TB] FAIL rst_status: got %h want 1", d); end
  endtask

  task automatic test_random();
    int kind;
    for (int i = 0; i < 600; i++) begin
      fifo_in_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0 && fq.size() < 4) begin
        fq.push_back(OUTW'($urandom));
        driveFifoOut();
      end
      kind = $urandom_range(0, 9);
      addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(0, 5));
      wdata = $urandom;
      wr_en = (kind < 4);
      rd_en = (kind >= 4 && kind < 8);
      tick();
      n_checks++; if (s_push !== e_push) begin n_fail++; $display("[TB] FAIL rand_push @%0d: got %b want %b", i, s_push, e_push); end
      n_checks++; if (s_pop !== e_pop) begin n_fail++; $display("[TB] FAIL rand_pop @%0d: got %b want %b", i, s_pop, e_pop); end
      n_checks++; if (s_irq !== e_irq) begin n_fail++; $display("[TB] FAIL rand_irq @%0d: got %b want %b", i, s_irq, e_irq); end
      n_checks++; if (s_rdata !== e_rdata) begin n_fail++; $display("[TB] FAIL rand_rdata @%0d addr=%0d: got %h want %h", i, addr, s_rdata, e_rdata); end
      n_checks++; if (s_fid !== e_fid) begin n_fail++; $display("[TB] FAIL rand_fifo_in_data @%0d: got %h want %h", i, s_fid, e_fid); end
      wr_en = 1'b0;
      rd_en = 1'b0;
    end
    fifo_in_full = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    addr = '0;
    wdata = '0;
    fifo_in_full = 1'b0;
    driveFifoOut();
    modelReset();
    test_reset();
    test_push();
    test_full_backpressure();
    test_busy_err();
    test_result();
    test_irq();
    test_reset_mid_pending();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
